fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Fetch-stage sequencer that owns the program counter register's load/next-value inputs and the instruction-cache read port. Each cycle it chooses between holding, advancing by 4, or redirecting to a branch/jump target. It handles multi-cycle cache responses, decode-stage backpressure and redirects that arrive mid-transaction. It sits between the PC register, the I-cache and the IF/ID pipeline register.

## Interface
- width, 32, PC/address width
- RESET_VEC, 32'h00000060, PC reset value; the PC register resets to the same value
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc  in  width  current PC, from the PC register output
- pc_load  out  1  load strobe to the PC register
- pc_next  out  width  value to load into the PC register
- icache_read  out  1  instruction read request
- icache_address  out  width  read address; always equals pc
- icache_resp  in  1  read complete; valid for one cycle
- icache_rdata  in  32  instruction data, valid with icache_resp
- stall  in  1  decode stage cannot accept an instruction this cycle
- redirect  in  1  branch/jump taken, from EX
- redirect_target  in  width  new PC for redirect
- if_valid  out  1  instruction presented to IF/ID this cycle
- if_pc  out  width  PC of the presented instruction
- if_instr  out  32  presented instruction

## Operation
- States: IDLE, REQ, HOLD, SQUASH. Internal registers: state, held instr (32b), target_q (width).
- IDLE: entered on reset and held for 1 cycle; no read; icache_resp ignored; next state is REQ.
- REQ: icache_read=1.
  - redirect with icache_resp: drop the data (if_valid=0), pc_load=1, pc_next=redirect_target, stay in REQ.
  - redirect without icache_resp: target_q<=redirect_target, go to SQUASH; no pc_load, so the address stays stable.
  - icache_resp with stall=0: if_valid=1, if_instr=icache_rdata, if_pc=pc, pc_load=1, pc_next=pc+4, stay in REQ.
  - icache_resp with stall=1: held instr<=icache_rdata, go to HOLD, no pc_load.
  - otherwise stay in REQ, address held.
- HOLD: icache_read=0; if_valid=1 with held instr, if_pc=pc.
  - redirect (priority over everything): if_valid=0, pc_load with redirect_target, go to REQ.
  - stall=0: the instruction is consumed this cycle; pc_load with pc+4, go to REQ.
  - stall=1: stay in HOLD.
- SQUASH: icache_read=1, if_valid=0.
  - A new redirect overwrites target_q; the newest redirect wins.
  - icache_resp: discard the data, pc_load=1, pc_next=target_q, go to REQ. If redirect and icache_resp occur together, redirect_target is used directly.
- stall is ignored in IDLE and SQUASH; only if_valid cycles are gated by it.
- pc+4 is computed modulo 2^width; 0xFFFFFFFC advances to 0x00000000.
- When pc_load=0, pc_next=pc+4 (don't-care value, but driven).
- if_valid, if_instr, if_pc, pc_load, pc_next and icache_read are combinational from state and inputs. Only state, held instr and target_q are registered.

## Timing
- Reset values while rst=1:
  - state=IDLE, held instr=0, target_q=0.
  - pc_load=0, icache_read=0, if_valid=0, if_instr=0, if_pc=pc.
- Reset mid-operation in any state aborts the outstanding transaction. icache_read drops in the reset cycle and the pending redirect is lost.
- First cycle after reset release: IDLE. Second cycle: REQ with address 0x60.
- A cache responding in the same cycle gives one instruction per cycle, back-to-back, with pc_load every cycle.
- A response latency of N cycles gives N+1 cycles per instruction in REQ, with address and read held steady throughout.
- Redirect-to-request latency:
  - 1 cycle when no transaction is outstanding, or when the response coincides with the redirect.
  - Otherwise the block waits for the outstanding response, then takes 1 more cycle.
- icache_read is never deasserted while a transaction is outstanding, except under reset.

## Test plan
- Reset, then a zero-latency cache returning 0x00000013 -> requests at 0x60, 0x64, 0x68 on consecutive cycles; if_valid=1 each cycle with the matching if_pc.
- Response latency 3 at 0x60 -> icache_read high and address 0x60 for 4 cycles; a single if_valid pulse; the next request is at 0x64.
- stall=1 for 2 cycles when the response arrives -> HOLD for 2 cycles with icache_read=0 and if_valid=1 with an unchanged instr; pc_load to 0x64 in the release cycle.
- redirect to 0x200 one cycle into a 3-cycle read of 0x60 -> address stays 0x60 until the response; the data is discarded (if_valid=0); the next request is at 0x200.
- redirect to 0x400 in the same cycle as the response, and separately while in HOLD -> if_valid=0, pc_load=1, pc_next=0x400.
- pc=0xFFFFFFFC with a response -> pc_next=0x00000000. Asserting rst while in HOLD/SQUASH -> the next cycle shows IDLE with all outputs at reset values, then a request at 0x60.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch sequencer bus: PC register load port, I-cache read port and the
// IF/ID presentation signals, bundled so the sequencer and its neighbours
// share one connection.
interface fetch_pc_ctrl_if #(
  parameter int width = 32
);
  // PC register side
  logic [width-1:0] pc;
  logic             pc_load;
  logic [width-1:0] pc_next;

  // I-cache read port
  logic             icache_read;
  logic [width-1:0] icache_address;
  logic             icache_resp;
  logic [31:0]      icache_rdata;

  // Decode / execute feedback
  logic             stall;
  logic             redirect;
  logic [width-1:0] redirect_target;

  // IF/ID presentation
  logic             if_valid;
  logic [width-1:0] if_pc;
  logic [31:0]      if_instr;

  // The fetch sequencer drives the load strobe, the cache request and the
  // presented instruction.
  modport master (
    input  pc,
    output pc_load,
    output pc_next,
    output icache_read,
    output icache_address,
    input  icache_resp,
    input  icache_rdata,
    input  stall,
    input  redirect,
    input  redirect_target,
    output if_valid,
    output if_pc,
    output if_instr
  );

  // PC register, I-cache and pipeline neighbours see the mirror image.
  modport slave (
    output pc,
    input  pc_load,
    input  pc_next,
    input  icache_read,
    input  icache_address,
    output icache_resp,
    output icache_rdata,
    output stall,
    output redirect,
    output redirect_target,
    input  if_valid,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage sequencer. Decides each cycle whether the PC holds, advances
// by 4 or jumps to a redirect target, keeps the I-cache request stable for
// the whole of a multi-cycle read, parks a returned instruction while decode
// is stalled, and defers a redirect that lands mid-read until the
// outstanding response has drained.
//
// Only state_r, held_instr_r and target_q_r are registers; every bus output
// is combinational from them and the current inputs, so a same-cycle cache
// gives one instruction per clock.
module fetch_pc_ctrl #(
  parameter int               width     = 32,
  parameter logic [width-1:0] RESET_VEC = width'(32'h0000_0060)
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_ctrl_if.master bus
);

  // The cache address is the PC itself, so a reset vector that is not
  // word aligned would put the very first fetch off a word boundary.
  if (RESET_VEC[1:0] != 2'b00) begin : g_reset_vec_check
    $error("fetch_pc_ctrl: RESET_VEC must be word aligned");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // one quiet cycle after reset, no request
    REQ    = 2'd1,  // read outstanding at the current PC
    HOLD   = 2'd2,  // instruction parked, waiting for decode to accept it
    SQUASH = 2'd3   // redirect seen mid-read, draining the stale response
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      held_instr_r;
  logic [31:0]      held_instr_nxt_s;
  logic [width-1:0] target_q_r;
  logic [width-1:0] target_q_nxt_s;

  // Sequential PC step; wraps naturally at 2^width.
  logic [width-1:0] pc_inc_s;

  logic             pc_load_s;
  logic [width-1:0] pc_next_s;
  logic             icache_read_s;
  logic             if_valid_s;
  logic [width-1:0] if_pc_s;
  logic [31:0]      if_instr_s;

  assign pc_inc_s = bus.pc + width'(32'd4);

  // Output decode and next-state selection for the fetch sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    held_instr_nxt_s = held_instr_r;
    target_q_nxt_s   = target_q_r;
    pc_load_s        = 1'b0;
    pc_next_s        = pc_inc_s;
    icache_read_s    = 1'b0;
    if_valid_s       = 1'b0;
    if_pc_s          = bus.pc;
    if_instr_s       = 32'd0;

    if (rst) begin
      // Reset drops the request and forgets any pending redirect.
      state_nxt_s      = IDLE;
      held_instr_nxt_s = 32'd0;
      target_q_nxt_s   = {width{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // The PC register is settling on the reset vector; a stray
          // response here belongs to nothing and is ignored.
          state_nxt_s = REQ;
        end

        REQ: begin
          icache_read_s = 1'b1;
          if (bus.redirect) begin
            if (bus.icache_resp) begin
              // Read just finished: drop it and jump straight away.
              pc_load_s = 1'b1;
              pc_next_s = bus.redirect_target;
            end else begin
              // Read still in flight: keep the address stable and jump
              // once the stale response comes back.
              target_q_nxt_s = bus.redirect_target;
              state_nxt_s    = SQUASH;
            end
          end else if (bus.icache_resp) begin
            if (!bus.stall) begin
              if_valid_s = 1'b1;
              if_instr_s = bus.icache_rdata;
              pc_load_s  = 1'b1;
              pc_next_s  = pc_inc_s;
            end else begin
              // Decode busy: park the word, PC stays put until it is taken.
              held_instr_nxt_s = bus.icache_rdata;
              state_nxt_s      = HOLD;
            end
          end else begin
            state_nxt_s = REQ;
          end
        end

        HOLD: begin
          if (bus.redirect) begin
            // The parked instruction is on the wrong path.
            pc_load_s   = 1'b1;
            pc_next_s   = bus.redirect_target;
            state_nxt_s = REQ;
          end else begin
            if_valid_s = 1'b1;
            if_instr_s = held_instr_r;
            if (!bus.stall) begin
              pc_load_s   = 1'b1;
              pc_next_s   = pc_inc_s;
              state_nxt_s = REQ;
            end else begin
              state_nxt_s = HOLD;
            end
          end
        end

        SQUASH: begin
          // Request stays up until the outstanding response is drained.
          icache_read_s = 1'b1;
          if (bus.icache_resp) begin
            pc_load_s   = 1'b1;
            state_nxt_s = REQ;
            if (bus.redirect) begin
              pc_next_s = bus.redirect_target;
            end else begin
              pc_next_s = target_q_r;
            end
          end else if (bus.redirect) begin
            // Newest redirect wins.
            target_q_nxt_s = bus.redirect_target;
          end else begin
            state_nxt_s = SQUASH;
          end
        end

        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, parked instruction and deferred redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      held_instr_r <= 32'd0;
      target_q_r   <= {width{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      held_instr_r <= held_instr_nxt_s;
      target_q_r   <= target_q_nxt_s;
    end
  end

  assign bus.pc_load        = pc_load_s;
  assign bus.pc_next        = pc_next_s;
  assign bus.icache_read    = icache_read_s;
  assign bus.icache_address = bus.pc;
  assign bus.if_valid       = if_valid_s;
  assign bus.if_pc          = if_pc_s;
  assign bus.if_instr       = if_instr_s;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: a behavioural PC register plus
// hand-driven cache responses, stalls and redirects, checked every cycle
// against hand-computed values.
module tb_fetch_pc_ctrl;
  localparam logic [31:0] RV = 32'h0000_0060;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fetch_pc_ctrl_if #(.width(32)) bus ();

  fetch_pc_ctrl #(.width(32), .RESET_VEC(RV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model
  always @(posedge clk) begin
    if (rst) bus.pc <= RV;
    else if (bus.pc_load) bus.pc <= bus.pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, then checks follow.
  task automatic cyc(input logic r, input logic resp, input logic [31:0] rd,
                     input logic st, input logic rdr, input logic [31:0] tgt);
    @(negedge clk);
    rst                 = r;
    bus.icache_resp     = resp;
    bus.icache_rdata    = rd;
    bus.stall           = st;
    bus.redirect        = rdr;
    bus.redirect_target = tgt;
    #1;
  endtask

  task automatic chk3(input string tag, input logic rd, input logic vld, input logic ld);
    chk({tag, ".read"},  {31'd0, bus.icache_read}, {31'd0, rd});
    chk({tag, ".valid"}, {31'd0, bus.if_valid},    {31'd0, vld});
    chk({tag, ".load"},  {31'd0, bus.pc_load},     {31'd0, ld});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.icache_resp = 1'b0; bus.icache_rdata = 32'd0; bus.stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_target = 32'd0;

    // Reset values
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.instr", bus.if_instr, 32'd0);
    chk("rst.if_pc", bus.if_pc, 32'h60);

    // IDLE ignores a stray response
    cyc(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'd0);
    chk3("idle", 1'b0, 1'b0, 1'b0);

    // Zero-latency cache, back-to-back fetches
    cyc(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'd0);
    chk3("z0", 1'b1, 1'b1, 1'b1);
    chk("z0.addr", bus.icache_address, 32'h60);
    chk("z0.if_pc", bus.if_pc, 32'h60);
    chk("z0.instr", bus.if_instr, 32'h13);
    chk("z0.next", bus.pc_next, 32'h64);
    cyc(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'd0);
    chk3("z1", 1'b1, 1'b1, 1'b1);
    chk("z1.if_pc", bus.if_pc, 32'h64);
    chk("z1.next", bus.pc_next, 32'h68);
    cyc(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 32'd0);
    chk("z2.if_pc", bus.if_pc, 32'h68);
    chk("z2.next", bus.pc_next, 32'h6C);

    // Latency-3 read at 0x6C: four cycles of steady request
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      chk3("lat.wait", 1'b1, 1'b0, 1'b0);
      chk("lat.addr", bus.icache_address, 32'h6C);
      chk("lat.next_dc", bus.pc_next, 32'h70);
    end
    cyc(1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 32'd0);
    chk3("lat.resp", 1'b1, 1'b1, 1'b1);
    chk("lat.instr", bus.if_instr, 32'hAAAA_0001);
    chk("lat.next", bus.pc_next, 32'h70);

    // Stall on response at 0x70 -> HOLD for two cycles
    cyc(1'b0, 1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 32'd0);
    chk("st.addr", bus.icache_address, 32'h70);
    chk3("st.resp", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
      chk3("hold", 1'b0, 1'b1, 1'b0);
      chk("hold.instr", bus.if_instr, 32'hBBBB_0002);
      chk("hold.if_pc", bus.if_pc, 32'h70);
    end
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("hold.rel", 1'b0, 1'b1, 1'b1);
    chk("hold.rel.instr", bus.if_instr, 32'hBBBB_0002);
    chk("hold.rel.next", bus.pc_next, 32'h74);

    // Redirect to 0x200 one cycle into a read of 0x74
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("rd.addr0", bus.icache_address, 32'h74);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h200);
    chk3("rd.req", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk3("sq.wait", 1'b1, 1'b0, 1'b0);
    chk("sq.addr", bus.icache_address, 32'h74);
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    chk3("sq.resp", 1'b1, 1'b0, 1'b1);
    chk("sq.next", bus.pc_next, 32'h200);

    // Redirect coincident with response in REQ
    cyc(1'b0, 1'b1, 32'h5555_0003, 1'b0, 1'b1, 32'h400);
    chk("co.addr", bus.icache_address, 32'h200);
    chk3("co", 1'b1, 1'b0, 1'b1);
    chk("co.next", bus.pc_next, 32'h400);

    // Redirect while in HOLD
    cyc(1'b0, 1'b1, 32'h6666_0004, 1'b1, 1'b0, 32'd0);
    chk("hr.addr", bus.icache_address, 32'h400);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h400);
    chk3("hr", 1'b0, 1'b0, 1'b1);
    chk("hr.next", bus.pc_next, 32'h400);

    // Newest redirect wins in SQUASH
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h600);
    chk3("sq2.redir", 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    chk("sq2.next", bus.pc_next, 32'h600);

    // Redirect with response in SQUASH uses the live target
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h700);
    cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk3("sq3", 1'b1, 1'b0, 1'b1);
    chk("sq3.next", bus.pc_next, 32'hFFFF_FFFC);

    // PC wrap
    cyc(1'b0, 1'b1, 32'h7777_0005, 1'b0, 1'b0, 32'd0);
    chk("wrap.if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap.next", bus.pc_next, 32'h0);

    // Reset while in HOLD
    cyc(1'b0, 1'b1, 32'h8888_0006, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk3("hrst.hold", 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    chk3("hrst.rst", 1'b0, 1'b0, 1'b0);
    chk("hrst.instr", bus.if_instr, 32'd0);
    cyc(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("hrst.idle", 1'b0, 1'b0, 1'b0);
    chk("hrst.if_pc", bus.if_pc, 32'h60);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("hrst.req", 1'b1, 1'b0, 1'b0);
    chk("hrst.addr", bus.icache_address, 32'h60);

    // Reset while in SQUASH: pending redirect lost
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h800);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("srst.rst", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    chk3("srst.idle", 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 32'h9999_0007, 1'b0, 1'b0, 32'd0);
    chk3("srst.req", 1'b1, 1'b1, 1'b1);
    chk("srst.addr", bus.icache_address, 32'h60);
    chk("srst.next", bus.pc_next, 32'h64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
